// File: rtl/imem_loader_if.sv
// Byte-stream input, control/status and imem write port of the instruction-memory loader.
// The loader connects through the slave modport; the byte source / controller uses master.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] imem_address;
    logic [DATA_WIDTH-1:0] imem_data;
    logic                  imem_wren;
    logic                  cpu_hold;
    logic                  done;
    logic                  error;

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, imem_address, imem_data, imem_wren, cpu_hold, done, error
    );

    modport master (
        output start, in_valid, in_data,
        input  in_ready, imem_address, imem_data, imem_wren, cpu_hold, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Fills imem from a byte stream: 16-bit word count header, then MSB-first 32-bit words
// written to consecutive addresses from 0; holds the CPU in reset until the load completes.
module imem_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    imem_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_BYTES,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    // Counts above this cannot fit; exactly this many is a full, legal image.
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

    state_t                r_state;
    logic [15:0]           r_count;
    logic [ADDR_WIDTH-1:0] r_word_idx;
    logic [1:0]            r_byte_idx;
    logic [DATA_WIDTH-1:0] r_word;
    logic                  r_in_ready;
    logic                  r_wren;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_done;
    logic                  r_error;
    logic                  r_cpu_hold;

    logic                  w_xfer;
    logic [15:0]           w_len;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_last;

    assign w_xfer = bus.in_valid & r_in_ready;
    assign w_len  = {r_count[15:8], bus.in_data};
    assign w_word = {r_word[DATA_WIDTH-9:0], bus.in_data};
    assign w_last = (17'(r_word_idx) == (17'(r_count) - 17'd1));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
            r_in_ready <= 1'b0;
            r_wren     <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cpu_hold <= 1'b1;
        end else begin
            r_wren <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state    <= S_LEN_HI;
                        r_in_ready <= 1'b1;
                    end
                end
                S_LEN_HI: begin
                    if (w_xfer) begin
                        r_count[15:8] <= bus.in_data;
                        r_state       <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_xfer) begin
                        r_count <= w_len;
                        if (w_len == 16'd0) begin
                            r_state    <= S_DONE;
                            r_in_ready <= 1'b0;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else if ({1'b0, w_len} > CAPACITY) begin
                            r_state    <= S_ERR;
                            r_in_ready <= 1'b0;
                            r_error    <= 1'b1;
                        end else begin
                            r_state    <= S_BYTES;
                            r_word_idx <= '0;
                            r_byte_idx <= '0;
                        end
                    end
                end
                S_BYTES: begin
                    if (w_xfer) begin
                        r_word     <= w_word;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_state    <= S_WRITE;
                            r_in_ready <= 1'b0;
                            r_wren     <= 1'b1;
                            r_addr     <= r_word_idx;
                            r_data     <= w_word;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_last) begin
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
                    end else begin
                        r_state    <= S_BYTES;
                        r_word_idx <= r_word_idx + ADDR_WIDTH'(1);
                        r_byte_idx <= '0;
                        r_in_ready <= 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    if (bus.start) begin
                        r_state    <= S_LEN_HI;
                        r_in_ready <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_cpu_hold <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.imem_wren    = r_wren;
    assign bus.imem_address = r_addr;
    assign bus.imem_data    = r_data;
    assign bus.done         = r_done;
    assign bus.error        = r_error;
    assign bus.cpu_hold     = r_cpu_hold;
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load scenarios plus hand-written
// sequences; imem writes are checked against a scoreboard of expected (address, data).
module tb_imem_loader;
    localparam int AW = 12;
    localparam int DW = 32;

    logic clock;
    logic reset;

    imem_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        string       name;
        logic [15:0] len;
        logic [31:0] seed;
        logic [31:0] step;
        logic        exp_done;
        logic        exp_error;
        int unsigned exp_writes;
    } vec_t;

    wr_t         sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned wren_count = 0;
    int unsigned xfer_count = 0;
    logic [AW-1:0] last_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Monitor: away from the active edge, count transfers and score imem writes.
    always @(negedge clock) begin
        if (bus.in_valid && bus.in_ready) xfer_count++;
        if (bus.imem_wren) begin
            wren_count++;
            last_addr = bus.imem_address;
            if (sb.size() == 0) begin
                fail_bound("unexpected_write");
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 32'(bus.imem_address), 32'(e.addr));
                check("wr_data", bus.imem_data, e.data);
            end
        end
    end

    // All driver tasks are entered and left at posedge+1.
    task automatic idle_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        idle_cycle();
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(negedge clock);
        while (!bus.in_ready && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        if (!bus.in_ready) fail_bound("byte_accept");
        idle_cycle();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [AW-1:0] addr, input logic [31:0] w);
        wr_t e;
        e.addr = addr;
        e.data = w;
        sb.push_back(e);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic wait_drain();
        int unsigned k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clock);
            k++;
        end
        if (sb.size() != 0) begin
            fail_bound("write_drain");
            sb.delete();
        end
        idle_cycle();
        idle_cycle();
    endtask

    vec_t vecs[4];

    initial begin
        int unsigned w0;
        int unsigned x0;

        vecs[0] = '{"two_words",  16'd2,    32'h12345678, 32'h88888878, 1'b1, 1'b0, 2};
        vecs[1] = '{"zero_len",   16'd0,    32'h0,        32'h0,        1'b1, 1'b0, 0};
        vecs[2] = '{"over_cap",   16'h1001, 32'h0,        32'h0,        1'b0, 1'b1, 0};
        vecs[3] = '{"three_words",16'd3,    32'hDEADBEEF, 32'h01010101, 1'b1, 1'b0, 3};

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        idle_cycle();
        idle_cycle();
        reset = 1'b0;

        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_wren",     32'(bus.imem_wren), 0);
        check("rst_addr",     32'(bus.imem_address), 0);
        check("rst_data",     bus.imem_data, 0);
        check("rst_done",     32'(bus.done), 0);
        check("rst_error",    32'(bus.error), 0);
        check("rst_hold",     32'(bus.cpu_hold), 1);

        for (int v = 0; v < 4; v++) begin
            w0 = wren_count;
            pulse_start();
            check({vecs[v].name, "_start_ready"}, 32'(bus.in_ready), 1);
            check({vecs[v].name, "_start_done"},  32'(bus.done), 0);
            check({vecs[v].name, "_start_error"}, 32'(bus.error), 0);
            check({vecs[v].name, "_start_hold"},  32'(bus.cpu_hold), 1);
            send_byte(vecs[v].len[15:8]);
            send_byte(vecs[v].len[7:0]);
            for (int i = 0; i < int'(vecs[v].exp_writes); i++)
                send_word(AW'(i), vecs[v].seed + 32'(i) * vecs[v].step);
            wait_drain();
            check({vecs[v].name, "_done"},     32'(bus.done), 32'(vecs[v].exp_done));
            check({vecs[v].name, "_error"},    32'(bus.error), 32'(vecs[v].exp_error));
            check({vecs[v].name, "_hold"},     32'(bus.cpu_hold), 32'(!vecs[v].exp_done));
            check({vecs[v].name, "_in_ready"}, 32'(bus.in_ready), 0);
            check({vecs[v].name, "_writes"},   wren_count - w0, vecs[v].exp_writes);
        end

        // N=1 with toggling valid, a 10-cycle gap after byte 2, and an ignored start mid-word.
        w0 = wren_count;
        pulse_start();
        x0 = xfer_count;
        send_byte(8'h00); idle_cycle();
        send_byte(8'h01); idle_cycle();
        begin
            wr_t e;
            e.addr = '0;
            e.data = 32'hA1B2C3D4;
            sb.push_back(e);
        end
        send_byte(8'hA1); idle_cycle();
        send_byte(8'hB2);
        repeat (4) idle_cycle();
        pulse_start();
        repeat (5) idle_cycle();
        send_byte(8'hC3); idle_cycle();
        send_byte(8'hD4);
        wait_drain();
        check("toggle_xfers", xfer_count - x0, 6);
        check("toggle_writes", wren_count - w0, 1);
        check("toggle_done", 32'(bus.done), 1);
        check("toggle_hold", 32'(bus.cpu_hold), 0);

        // Reset after 2 of 3 words, then bytes in IDLE are refused, then a fresh load from 0.
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h03);
        send_word(AW'(0), 32'h11112222);
        send_word(AW'(1), 32'h33334444);
        wait_drain();
        send_byte(8'h55);
        reset = 1'b1;
        idle_cycle();
        reset = 1'b0;
        check("midrst_in_ready", 32'(bus.in_ready), 0);
        check("midrst_hold",     32'(bus.cpu_hold), 1);
        check("midrst_done",     32'(bus.done), 0);
        check("midrst_wren",     32'(bus.imem_wren), 0);
        x0 = xfer_count;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        repeat (5) idle_cycle();
        bus.in_valid = 1'b0;
        check("idle_no_xfer", xfer_count - x0, 0);
        w0 = wren_count;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(AW'(0), 32'hCAFEF00D);
        wait_drain();
        check("reload_writes", wren_count - w0, 1);
        check("reload_done", 32'(bus.done), 1);

        // Full-capacity load: address must reach all-ones without wrapping.
        w0 = wren_count;
        pulse_start();
        send_byte(8'h10);
        send_byte(8'h00);
        for (int i = 0; i < 4096; i++)
            send_word(AW'(i), 32'h1000_0000 + 32'(i));
        wait_drain();
        check("full_writes",    wren_count - w0, 4096);
        check("full_last_addr", 32'(last_addr), 32'hFFF);
        check("full_hold_addr", 32'(bus.imem_address), 32'hFFF);
        check("full_hold_data", bus.imem_data, 32'h1000_0FFF);
        check("full_done",      32'(bus.done), 1);
        check("full_hold",      32'(bus.cpu_hold), 0);
        check("full_error",     32'(bus.error), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
